// File: rtl/counter_to_99_if.sv
// Enable/carry bundle of the mod-100 BCD counter stage.
// The master drives the count enable and receives the two carry flags.
interface counter_to_99_if;
  logic x;
  logic y1;
  logic y2;

  modport master (
    output x,
    input  y1,
    input  y2
  );

  modport slave (
    input  x,
    output y1,
    output y2
  );
endinterface

// File: rtl/counter_to_99.sv
// Cascadable two-digit BCD event counter (00..99).
// Reports the units carry (y1) and the full-count carry (y2) combinationally.
module counter_to_99 (
  input  logic            clk,
  input  logic            reset,
  counter_to_99_if.slave  bus
);

  logic [3:0] units;
  logic [3:0] tens;
  logic       units_top;
  logic       tens_top;

  // Codes 10..15 can only appear after an uninitialised power-up.
  // Treating them as 9 makes the next enabled edge clear that digit.
  function automatic logic digit_top(input logic [3:0] d);
    return (d >= 4'd9);
  endfunction

  function automatic logic [3:0] digit_next(input logic [3:0] d);
    return digit_top(d) ? 4'd0 : d + 4'd1;
  endfunction

  assign units_top = digit_top(units);
  assign tens_top  = digit_top(tens);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else if (bus.x) begin
      units <= digit_next(units);
      if (units_top) begin
        tens <= digit_next(tens);
      end
    end
  end

  // Flags report legal 9s only, so y2 always implies y1.
  assign bus.y1 = bus.x & (units == 4'd9);
  assign bus.y2 = bus.x & (units == 4'd9) & (tens == 4'd9);

  logic unused_top;
  assign unused_top = tens_top;

endmodule

// File: tb/tb_counter_to_99.sv
// Directed bench for counter_to_99: the count is observed only through y1/y2,
// so each expected flag value follows from the hand-tracked count.
module tb_counter_to_99;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   y1_seen;
  int   y2_seen;

  counter_to_99_if bus ();

  counter_to_99 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    bus.x  = 1'b1;

    // Reset held with x=1 across several edges: flags stay low.
    #1;
    chk("rst_y1_t0", bus.y1, 1'b0);
    chk("rst_y2_t0", bus.y2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_y1_edge", bus.y1, 1'b0);
      chk("rst_y2_edge", bus.y2, 1'b0);
    end

    // Release: 9 edges reach 09, 10th edge reaches 10.
    reset = 1'b0;
    tick(9);
    chk("cnt09_y1", bus.y1, 1'b1);
    chk("cnt09_y2", bus.y2, 1'b0);
    tick(1);
    chk("cnt10_y1", bus.y1, 1'b0);
    chk("cnt10_y2", bus.y2, 1'b0);

    // Back to 00, then 99 edges reach 99.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick(98);
    chk("cnt98_y1", bus.y1, 1'b0);
    tick(1);
    chk("cnt99_y1", bus.y1, 1'b1);
    chk("cnt99_y2", bus.y2, 1'b1);

    // x=0 drops both flags at once; count holds across 5 edges.
    bus.x = 1'b0;
    #1;
    chk("hold_y1_now", bus.y1, 1'b0);
    chk("hold_y2_now", bus.y2, 1'b0);
    tick(5);
    chk("hold_y1_5", bus.y1, 1'b0);
    bus.x = 1'b1;
    #1;
    chk("rearm_y1", bus.y1, 1'b1);
    chk("rearm_y2", bus.y2, 1'b1);
    tick(1);
    chk("wrap00_y1", bus.y1, 1'b0);
    chk("wrap00_y2", bus.y2, 1'b0);

    // Count to 37, then 39, then asynchronous reset between edges.
    tick(37);
    chk("cnt37_y1", bus.y1, 1'b0);
    tick(2);
    chk("cnt39_y1", bus.y1, 1'b1);
    chk("cnt39_y2", bus.y2, 1'b0);
    reset = 1'b1;
    #2;
    chk("async_rst_y1", bus.y1, 1'b0);
    chk("async_rst_y2", bus.y2, 1'b0);
    tick(1);
    chk("rst_hold_y1", bus.y1, 1'b0);
    reset = 1'b0;
    tick(1);
    chk("resume01_y1", bus.y1, 1'b0);
    tick(8);
    chk("resume09_y1", bus.y1, 1'b1);
    chk("resume09_y2", bus.y2, 1'b0);

    // 250 enabled edges from 00: flags counted per visited state.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    y1_seen = 0;
    y2_seen = 0;
    for (int i = 0; i < 250; i++) begin
      if (bus.y1 === 1'b1) y1_seen++;
      if (bus.y2 === 1'b1) y2_seen++;
      tick(1);
    end
    chk_int("run250_y1_cycles", y1_seen, 25);
    chk_int("run250_y2_cycles", y2_seen, 2);
    chk("cnt50_y1", bus.y1, 1'b0);
    tick(9);
    chk("cnt59_y1", bus.y1, 1'b1);
    chk("cnt59_y2", bus.y2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
